// File: rtl/date_set_ctrl.sv
// date_set_ctrl: set-mode date editor sitting between the debounced buttons
// and the date counter. Loads the running date on entry, edits it with
// up/down/next buttons (calendar-valid, leap-aware), pulses commit on exit.
// Optional feature: define AUTOREPEAT_EN for held-button auto-repeat.
module date_set_ctrl #(
  parameter int         YEAR_DIGITS   = 2,
  parameter logic [1:0] SET_CODE      = 2'b11,
  parameter int         REPEAT_DELAY  = 50,
  parameter int         REPEAT_PERIOD = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        button1,
  input  logic                        button2,
  input  logic                        button3,
  input  logic [1:0]                  set_mode,
  input  logic [16+4*YEAR_DIGITS-1:0] cur_date,
  input  logic [2:0]                  cur_weekday,
  output logic [3:0]                  day1,
  output logic [3:0]                  day2,
  output logic [3:0]                  month1,
  output logic [3:0]                  month2,
  output logic [4*YEAR_DIGITS-1:0]    year_bcd,
  output logic [2:0]                  day,
  output logic [1:0]                  field,
  output logic                        editing,
  output logic                        commit
);

  localparam int YW = 4 * YEAR_DIGITS;
  localparam int DW = 16 + YW;

  typedef enum logic {S_IDLE, S_EDIT} state_t;

  function automatic logic [7:0] bcd2bin(input logic [3:0] t, input logic [3:0] u);
    return ({4'd0, t} * 8'd10) + {4'd0, u};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [4:0] v);
    logic [3:0] t;
    logic [4:0] r;
    if (v >= 5'd30)      begin t = 4'd3; r = v - 5'd30; end
    else if (v >= 5'd20) begin t = 4'd2; r = v - 5'd20; end
    else if (v >= 5'd10) begin t = 4'd1; r = v - 5'd10; end
    else                 begin t = 4'd0; r = v;         end
    return {t, r[3:0]};
  endfunction

  // Century years (low pair 00) are leap only when the high pair is a multiple of 4.
  function automatic logic is_leap(input logic [YW-1:0] y);
    logic [15:0] yy;
    logic [7:0]  lo;
    logic [7:0]  hi;
    yy = 16'(y);
    lo = bcd2bin(yy[7:4], yy[3:0]);
    hi = bcd2bin(yy[15:12], yy[11:8]);
    if (YEAR_DIGITS == 4)
      return (lo[1:0] == 2'd0) && ((lo != 8'd0) || (hi[1:0] == 2'd0));
    return lo[1:0] == 2'd0;
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                     return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
      default:                  return 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] clamp_day(input logic [4:0] d, input logic [4:0] len);
    return (d > len) ? len : d;
  endfunction

  function automatic logic [YW-1:0] year_step(input logic [YW-1:0] y, input logic up);
    logic [YW-1:0] r;
    logic          c;
    logic [3:0]    d;
    r = y;
    c = 1'b1;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      d = r[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d >= 4'd9) d = 4'd0;
          else begin d = d + 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin d = d - 4'd1; c = 1'b0; end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic [YW-1:0] sat_year(input logic [YW-1:0] y);
    logic [YW-1:0] r;
    r = y;
    for (int i = 0; i < YEAR_DIGITS; i++)
      if (r[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  state_t          r_state, w_state_nxt;
  logic            r_b1_q, r_b2_q, r_b3_q, r_commit;
  logic [1:0]      r_mode_q;
  logic [4:0]      r_day, w_day_nxt;
  logic [3:0]      r_mon, w_mon_nxt, w_mon_step;
  logic [YW-1:0]   r_year, w_year_nxt, w_year_step;
  logic [2:0]      r_wday, w_wday_nxt;
  logic [1:0]      r_field, w_field_nxt;
  logic            w_entry, w_exit, w_act;
  logic            w_e1, w_e2, w_e3, w_fld, w_up, w_dn, w_fire_up, w_fire_dn;
  logic            w_leap;
  logic [4:0]      w_len;
  logic [7:0]      w_in_day_b, w_in_mon_b;
  logic [3:0]      w_in_mon;
  logic [YW-1:0]   w_in_year;
  logic [4:0]      w_in_len, w_in_day;
  logic [2:0]      w_in_wday;

  assign w_e1 = button1 & ~r_b1_q;
  assign w_e2 = button2 & ~r_b2_q;
  assign w_e3 = button3 & ~r_b3_q;

  // Entry-time sanitisation of the running date so the edit starts calendar-valid.
  assign w_in_day_b = bcd2bin(cur_date[DW-1 -: 4], cur_date[DW-5 -: 4]);
  assign w_in_mon_b = bcd2bin(cur_date[YW+4 +: 4], cur_date[YW +: 4]);
  assign w_in_year  = sat_year(cur_date[YW-1:0]);
  assign w_in_mon   = ((w_in_mon_b == 8'd0) || (w_in_mon_b > 8'd12)) ? 4'd1 : w_in_mon_b[3:0];
  assign w_in_len   = month_len(w_in_mon, is_leap(w_in_year));
  assign w_in_day   = (w_in_day_b == 8'd0) ? 5'd1 :
                      ((w_in_day_b > {3'd0, w_in_len}) ? w_in_len : w_in_day_b[4:0]);
  assign w_in_wday  = (cur_weekday == 3'd7) ? 3'd0 : cur_weekday;

  assign w_leap = is_leap(r_year);
  assign w_len  = month_len(r_mon, w_leap);

`ifdef AUTOREPEAT_EN
  localparam int CW = 16;
  logic          r_rep_act, r_rep_up, r_rep_phase;
  logic [CW-1:0] r_rep_cnt;
  logic          w_held, w_fire;

  assign w_held    = r_rep_up ? button1 : button2;
  assign w_fire    = r_rep_act & w_held &
                     (r_rep_cnt == (r_rep_phase ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY)));
  assign w_fire_up = w_fire & r_rep_up;
  assign w_fire_dn = w_fire & ~r_rep_up;

  // Repeat timer: counts cycles since the last step of the held up/down button.
  always_ff @(posedge clk) begin
    if (rst || !w_act || w_e3) begin
      r_rep_act   <= 1'b0;
      r_rep_phase <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (w_e1 || w_e2) begin
      r_rep_act   <= 1'b1;
      r_rep_up    <= w_e1;
      r_rep_phase <= 1'b0;
      r_rep_cnt   <= CW'(1);
    end else if (r_rep_act) begin
      if (!w_held) begin
        r_rep_act <= 1'b0;
      end else if (w_fire) begin
        r_rep_cnt   <= CW'(1);
        r_rep_phase <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + CW'(1);
      end
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign w_fire_up    = 1'b0;
  assign w_fire_dn    = 1'b0;
`endif

  // Single action per cycle: next-field beats up, up beats down.
  assign w_fld = w_act & w_e3;
  assign w_up  = w_act & ~w_e3 & (w_e1 | (~w_e2 & w_fire_up));
  assign w_dn  = w_act & ~w_e3 & ~w_e1 & (w_e2 | w_fire_dn);

  // FSM state register plus control history (buttons, mode, commit pulse).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_commit <= 1'b0;
      r_b1_q   <= 1'b0;
      r_b2_q   <= 1'b0;
      r_b3_q   <= 1'b0;
      r_mode_q <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_commit <= w_exit;
      r_b1_q   <= button1;
      r_b2_q   <= button2;
      r_b3_q   <= button3;
      r_mode_q <= set_mode;
    end
  end

  // FSM next state: enter on the rising match of set_mode, leave when it drops.
  always_comb begin
    w_state_nxt = r_state;
    w_entry     = 1'b0;
    w_exit      = 1'b0;
    w_act       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((set_mode == SET_CODE) && (r_mode_q != SET_CODE)) begin
          w_state_nxt = S_EDIT;
          w_entry     = 1'b1;
        end
      end
      default: begin
        if (set_mode != SET_CODE) begin
          w_state_nxt = S_IDLE;
          w_exit      = 1'b1;
        end else begin
          w_act = 1'b1;
        end
      end
    endcase
  end

  // Working-date next values: load on entry, otherwise apply the one action.
  always_comb begin
    w_day_nxt   = r_day;
    w_mon_nxt   = r_mon;
    w_year_nxt  = r_year;
    w_wday_nxt  = r_wday;
    w_field_nxt = r_field;
    w_mon_step  = r_mon;
    w_year_step = r_year;
    if (w_entry) begin
      w_day_nxt   = w_in_day;
      w_mon_nxt   = w_in_mon;
      w_year_nxt  = w_in_year;
      w_wday_nxt  = w_in_wday;
      w_field_nxt = 2'd0;
    end else if (w_fld) begin
      w_field_nxt = r_field + 2'd1;
    end else if (w_up || w_dn) begin
      case (r_field)
        2'd0: begin
          if (w_up) w_day_nxt = (r_day >= w_len) ? 5'd1 : r_day + 5'd1;
          else      w_day_nxt = (r_day <= 5'd1) ? w_len : r_day - 5'd1;
        end
        2'd1: begin
          if (w_up) w_mon_step = (r_mon >= 4'd12) ? 4'd1 : r_mon + 4'd1;
          else      w_mon_step = (r_mon <= 4'd1) ? 4'd12 : r_mon - 4'd1;
          w_mon_nxt = w_mon_step;
          w_day_nxt = clamp_day(r_day, month_len(w_mon_step, w_leap));
        end
        2'd2: begin
          w_year_step = year_step(r_year, w_up);
          w_year_nxt  = w_year_step;
          w_day_nxt   = clamp_day(r_day, month_len(r_mon, is_leap(w_year_step)));
        end
        default: begin
          if (w_up) w_wday_nxt = (r_wday >= 3'd6) ? 3'd0 : r_wday + 3'd1;
          else      w_wday_nxt = (r_wday == 3'd0) ? 3'd6 : r_wday - 3'd1;
        end
      endcase
    end
  end

  // Working-date registers; reset aborts any edit back to 01/01/0..0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_day   <= 5'd1;
      r_mon   <= 4'd1;
      r_year  <= '0;
      r_wday  <= 3'd0;
      r_field <= 2'd0;
    end else begin
      r_day   <= w_day_nxt;
      r_mon   <= w_mon_nxt;
      r_year  <= w_year_nxt;
      r_wday  <= w_wday_nxt;
      r_field <= w_field_nxt;
    end
  end

  assign {day1, day2}     = bin2bcd(r_day);
  assign {month1, month2} = bin2bcd({1'b0, r_mon});
  assign year_bcd         = r_year;
  assign day              = r_wday;
  assign field            = r_field;
  assign editing          = (r_state == S_EDIT);
  assign commit           = r_commit;

endmodule

// File: tb/tb_date_set_ctrl.sv
// Bench for date_set_ctrl: integer calendar model feeding a scoreboard queue,
// monitor compares every cycle, plus directed boundary scenarios.
module tb_date_set_ctrl;
  localparam int         YD   = 2;
  localparam int         YW   = 4 * YD;
  localparam int         DW   = 16 + YW;
  localparam int         YMAX = 10 ** YD;
  localparam int         RD   = 50;
  localparam int         RP   = 10;
  localparam logic [1:0] SC   = 2'b11;

  typedef logic [16+YW+3+2+2-1:0] snap_t;

  logic          clk = 1'b0;
  logic          rst, b1, b2, b3;
  logic [1:0]    mode;
  logic [DW-1:0] cur_date;
  logic [2:0]    cur_wd;
  logic [3:0]    day1, day2, month1, month2;
  logic [YW-1:0] year_bcd;
  logic [2:0]    wday;
  logic [1:0]    field;
  logic          editing, commit;

  int total = 0;
  int bad   = 0;
  int cycn  = 0;
  snap_t q[$];

  // model state (plain integers)
  int m_day, m_mon, m_year, m_wd, m_field, m_hold;
  bit m_edit, m_commit, p1, p2, p3, m_rep_act, m_rep_up;
  logic [1:0] pm;
  int ld_d, ld_m, ld_y;

  always #5 clk = ~clk;

  date_set_ctrl #(.YEAR_DIGITS(YD), .SET_CODE(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .button1(b1), .button2(b2), .button3(b3),
    .set_mode(mode), .cur_date(cur_date), .cur_weekday(cur_wd),
    .day1(day1), .day2(day2), .month1(month1), .month2(month2),
    .year_bcd(year_bcd), .day(wday), .field(field),
    .editing(editing), .commit(commit)
  );

  function automatic bit leap(int y);
    if (YD == 2) return (y % 4) == 0;
    return ((y % 4) == 0) && (((y % 100) != 0) || ((y % 400) == 0));
  endfunction

  function automatic int mlen(int m, int y);
    case (m)
      2:           return leap(y) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  function automatic logic [YW-1:0] ybcd(int y);
    logic [YW-1:0] r;
    int v;
    v = y;
    for (int i = 0; i < YD; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pack(int d, int m, int y);
    return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10), ybcd(y)};
  endfunction

  function automatic snap_t exp_snap();
    return {4'(m_day / 10), 4'(m_day % 10), 4'(m_mon / 10), 4'(m_mon % 10),
            ybcd(m_year), 3'(m_wd), 2'(m_field), m_edit, m_commit};
  endfunction

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic model_step();
    bit e1, e2, e3, up, dn, fire, cm;
    int len;
    if (rst) begin
      m_day = 1; m_mon = 1; m_year = 0; m_wd = 0; m_field = 0;
      m_edit = 0; m_commit = 0; p1 = 0; p2 = 0; p3 = 0; pm = 2'b00;
      m_rep_act = 0; m_hold = 0;
      return;
    end
    e1 = b1 && !p1; e2 = b2 && !p2; e3 = b3 && !p3;
    cm = m_edit && (mode != SC);
    if (!m_edit) begin
      m_rep_act = 0;
      if ((mode == SC) && (pm != SC)) begin
        ld_d = (cur_date[DW-1 -: 4] * 10) + cur_date[DW-5 -: 4];
        ld_m = (cur_date[YW+4 +: 4] * 10) + cur_date[YW +: 4];
        ld_y = 0;
        for (int i = YD - 1; i >= 0; i--) ld_y = ld_y * 10 + cur_date[4*i +: 4];
        m_mon  = (ld_m == 0 || ld_m > 12) ? 1 : ld_m;
        m_year = ld_y;
        len    = mlen(m_mon, m_year);
        m_day  = (ld_d == 0) ? 1 : ((ld_d > len) ? len : ld_d);
        m_wd   = (cur_wd == 3'd7) ? 0 : int'(cur_wd);
        m_field = 0;
        m_edit  = 1;
      end
    end else if (mode != SC) begin
      m_edit = 0;
      m_rep_act = 0;
    end else begin
      fire = 0;
`ifdef AUTOREPEAT_EN
      if (e3) m_rep_act = 0;
      else if (e1 || e2) begin m_rep_act = 1; m_rep_up = e1; m_hold = 0; end
      else if (m_rep_act) begin
        if (!(m_rep_up ? b1 : b2)) m_rep_act = 0;
        else begin
          m_hold++;
          fire = (m_hold == RD) || ((m_hold > RD) && (((m_hold - RD) % RP) == 0));
        end
      end
`endif
      if (e3) m_field = (m_field + 1) % 4;
      else begin
        up = e1 || (!e2 && fire && m_rep_up);
        dn = !e1 && (e2 || (fire && !m_rep_up));
        if (up || dn) begin
          case (m_field)
            0: begin
              len = mlen(m_mon, m_year);
              if (up) m_day = (m_day == len) ? 1 : m_day + 1;
              else    m_day = (m_day == 1) ? len : m_day - 1;
            end
            1: begin
              if (up) m_mon = (m_mon == 12) ? 1 : m_mon + 1;
              else    m_mon = (m_mon == 1) ? 12 : m_mon - 1;
              if (m_day > mlen(m_mon, m_year)) m_day = mlen(m_mon, m_year);
            end
            2: begin
              m_year = (m_year + (up ? 1 : -1) + YMAX) % YMAX;
              if (m_day > mlen(m_mon, m_year)) m_day = mlen(m_mon, m_year);
            end
            default: m_wd = up ? (m_wd + 1) % 7 : (m_wd + 6) % 7;
          endcase
        end
      end
    end
    m_commit = cm;
    p1 = b1; p2 = b2; p3 = b3; pm = mode;
  endtask

  task automatic cyc(input bit r, input bit x1, input bit x2, input bit x3, input logic [1:0] md);
    rst = r; b1 = x1; b2 = x2; b3 = x3; mode = md;
    model_step();
    @(posedge clk);
    q.push_back(exp_snap());
    #1;
  endtask

  task automatic enter(int d, int m, int y, int wd);
    cur_date = pack(d, m, y);
    cur_wd   = 3'(wd);
    cyc(0, 0, 0, 0, 2'b00);
    cyc(0, 0, 0, 0, SC);
  endtask

  task automatic press(int k);
    cyc(0, k == 1, k == 2, k == 3, SC);
    cyc(0, 0, 0, 0, SC);
  endtask

  // Scoreboard monitor: one expected snapshot per clock, compared mid-cycle.
  always @(negedge clk) begin
    snap_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if ({day1, day2, month1, month2, year_bcd, wday, field, editing, commit} !== e) begin
        bad++;
        $display("FAIL scoreboard cyc=%0d got=%h want=%h", cycn,
                 {day1, day2, month1, month2, year_bcd, wday, field, editing, commit}, e);
      end
    end
    cycn++;
  end

  initial begin
    bit x1, x2, x3;
    logic [1:0] md;
    rst = 1; b1 = 0; b2 = 0; b3 = 0; mode = 2'b00; cur_date = '0; cur_wd = 3'd0;
    cyc(1, 0, 0, 0, 2'b00);
    cyc(1, 0, 0, 0, 2'b00);
    chk("reset_day", {day1, day2}, 8'h01);
    chk("reset_edit", {editing, commit}, 0);

    // entry with sanitisation: 31/04/24 -> 30/04
    enter(31, 4, 24, 5);
    chk("entry_day", {day1, day2}, 8'h30);
    chk("entry_month", {month1, month2}, 8'h04);
    chk("entry_year", year_bcd, 8'h24);
    chk("entry_wday", wday, 5);
    chk("entry_field_edit", {field, editing}, 3'b001);

    // leap-year clamp
    enter(29, 2, 24, 0);
    press(3); press(1); press(1);
    chk("clamp_apr", {month1, month2, day1, day2}, 16'h0429);
    press(2); press(2); press(3); press(2);
    chk("clamp_feb23", {day1, day2}, 8'h28);
    chk("clamp_year", year_bcd, 8'h23);

    // wrap boundaries
    enter(1, 3, 99, 0);
    press(2);
    chk("wrap_day", {day1, day2}, 8'h31);
    press(3); press(3); press(1);
    chk("wrap_year", year_bcd, 8'h00);
    press(3); press(2);
    chk("wrap_wday", wday, 6);

    // priority: button1 and button3 together only advance the field
    enter(10, 5, 10, 2);
    cyc(0, 1, 0, 1, SC);
    chk("prio_field", field, 1);
    chk("prio_day", {day1, day2, month1, month2}, 16'h1005);
    cyc(0, 0, 0, 0, SC);
    press(3); press(3); press(3);
    for (int i = 0; i < 200; i++) cyc(0, 1, 0, 0, SC);
    cyc(0, 0, 0, 0, SC);
`ifdef AUTOREPEAT_EN
    chk("hold_day", {day1, day2}, 8'h26);
    enter(1, 1, 0, 0);
    for (int i = 0; i < 81; i++) cyc(0, 1, 0, 0, SC);
    cyc(0, 0, 0, 0, SC);
    chk("repeat_day", {day1, day2}, 8'h06);
`else
    chk("hold_day", {day1, day2}, 8'h11);
`endif

    // commit on exit
    cyc(0, 0, 0, 0, 2'b00);
    chk("commit_pulse", {commit, editing}, 2'b10);
    cyc(0, 0, 0, 0, 2'b00);
    chk("commit_gone", commit, 0);

    // abort by reset mid-edit
    enter(15, 6, 30, 3);
    press(1);
    chk("abort_pre", {day1, day2}, 8'h16);
    cyc(1, 0, 0, 0, SC);
    chk("abort_date", {day1, day2, month1, month2, year_bcd}, 24'h010100);
    chk("abort_wd_commit", {wday, commit, editing}, 0);
    cyc(0, 0, 0, 0, 2'b00);
    chk("abort_nocommit", commit, 0);

    // randomized traffic against the model
    x1 = 0; x2 = 0; x3 = 0; md = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) x1 = ~x1;
      if ($urandom_range(0, 3) == 0) x2 = ~x2;
      if ($urandom_range(0, 5) == 0) x3 = ~x3;
      if ($urandom_range(0, 40) == 0) md = (md == SC) ? 2'($urandom_range(0, 2)) : SC;
      cur_date = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      cur_wd = 3'($urandom_range(0, 7));
      cyc(($urandom_range(0, 499) == 0), x1, x2, x3, md);
    end
    cyc(0, 0, 0, 0, 2'b00);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
